// File: rtl/vga_box_bounce.sv
// vga_box_bounce: overlays a solid square on a caller-supplied background.
// The square advances once per frame (on the vs falling edge) and bounces
// off the edges of the active area. Pixel and sync outputs share one
// register stage, so they stay mutually aligned with one cycle of latency.
module vga_box_bounce #(
    parameter int         WIDTH     = 10,
    parameter int         H_OFS     = 144,
    parameter int         V_OFS     = 35,
    parameter int         H_ACT     = 640,
    parameter int         V_ACT     = 480,
    parameter int         BOX       = 32,
    parameter int         STEP      = 2,
    parameter logic [7:0] BOX_COLOR = 8'hE0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs,
    input  logic             vs,
    input  logic [WIDTH+1:0] line_cnt,
    input  logic [WIDTH+1:0] ver_cnt,
    input  logic             en,
    input  logic [7:0]       bg_rgb,
    output logic             hs_o,
    output logic             vs_o,
    output logic [7:0]       rgb_o,
    output logic             frame_tick,
    output logic [WIDTH-1:0] box_x,
    output logic [WIDTH-1:0] box_y
);

    localparam int CW = WIDTH + 2;   // scan counter width
    localparam int PW = WIDTH + 1;   // position arithmetic width (no overflow)

    localparam logic [CW-1:0] H_LO   = CW'(H_OFS);
    localparam logic [CW-1:0] H_HI   = CW'(H_OFS + H_ACT);
    localparam logic [CW-1:0] V_LO   = CW'(V_OFS);
    localparam logic [CW-1:0] V_HI   = CW'(V_OFS + V_ACT);
    localparam logic [CW-1:0] BOX_C  = CW'(BOX);
    localparam logic [PW-1:0] XMAX_W = PW'(H_ACT - BOX);
    localparam logic [PW-1:0] YMAX_W = PW'(V_ACT - BOX);
    localparam logic [PW-1:0] STEP_W = PW'(STEP);

    logic             vs_d;
    logic             x_dir;
    logic             y_dir;
    logic [WIDTH:0]   x_upd;
    logic [WIDTH:0]   y_upd;

    logic             active_p0;
    logic             inside_p0;
    logic [CW-1:0]    px_p0;
    logic [CW-1:0]    py_p0;
    logic [CW-1:0]    bx_p0;
    logic [CW-1:0]    by_p0;
    logic [7:0]       rgb_p0;

    // One axis of motion with clamping at both walls.
    // Returns {next_dir, next_pos}; the sum is taken one bit wider than the
    // position so a step past the far wall cannot wrap.
    function automatic logic [WIDTH:0] axis_next(input logic [WIDTH-1:0] pos,
                                                 input logic             dir,
                                                 input logic [PW-1:0]    lim);
        logic [PW-1:0] pos_w;
        logic [PW-1:0] nxt;
        pos_w = {1'b0, pos};
        nxt   = pos_w;
        if (dir) begin
            nxt = pos_w + STEP_W;
            if (nxt >= lim) axis_next = {1'b0, lim[WIDTH-1:0]};
            else            axis_next = {1'b1, nxt[WIDTH-1:0]};
        end else if (pos_w <= STEP_W) begin
            axis_next = {1'b1, {WIDTH{1'b0}}};
        end else begin
            nxt       = pos_w - STEP_W;
            axis_next = {1'b0, nxt[WIDTH-1:0]};
        end
    endfunction

    assign x_upd = axis_next(box_x, x_dir, XMAX_W);
    assign y_upd = axis_next(box_y, y_dir, YMAX_W);

    // Frame detect: one-cycle pulse the cycle after vs is first seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_d       <= vs;
            frame_tick <= vs_d & ~vs;
        end
    end

    // Position/direction update, only on a frame tick while motion is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= '0;
            box_y <= '0;
            x_dir <= 1'b1;
            y_dir <= 1'b1;
        end else if (frame_tick && en) begin
            {x_dir, box_x} <= x_upd;
            {y_dir, box_y} <= y_upd;
        end
    end

    // Stage p0: combinational decode of the current scan position.
    always_comb begin
        active_p0 = 1'b0;
        inside_p0 = 1'b0;
        px_p0     = line_cnt - H_LO;
        py_p0     = ver_cnt - V_LO;
        bx_p0     = {2'b00, box_x};
        by_p0     = {2'b00, box_y};
        rgb_p0    = 8'h00;
        active_p0 = (line_cnt >= H_LO) && (line_cnt < H_HI) &&
                    (ver_cnt  >= V_LO) && (ver_cnt  < V_HI);
        inside_p0 = (px_p0 >= bx_p0) && (px_p0 < bx_p0 + BOX_C) &&
                    (py_p0 >= by_p0) && (py_p0 < by_p0 + BOX_C);
        if (active_p0) rgb_p0 = inside_p0 ? BOX_COLOR : bg_rgb;
    end

    // Output register: pixel and syncs leave together, one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_o <= 8'h00;
            hs_o  <= 1'b1;
            vs_o  <= 1'b1;
        end else begin
            rgb_o <= rgb_p0;
            hs_o  <= hs;
            vs_o  <= vs;
        end
    end

endmodule

// File: doc/vga_box_bounce.md
# vga_box_bounce

Overlay stage between the VGA timing generator and the pixel output. It consumes the timing generator's sync signals and raw scan counters, and moves a solid square once per frame, bouncing it off the edges of the active area. It emits a sync-aligned, registered 8-bit RGB stream that composites the square over a caller-supplied background colour.

## Interface
Parameters:
- WIDTH, 10: counter width base; scan counters are WIDTH+2 bits.
- H_OFS, 144: line_cnt value of the first active pixel.
- V_OFS, 35: ver_cnt value of the first active line.
- H_ACT, 640: active pixels per line.
- V_ACT, 480: active lines per frame.
- BOX, 32: square side in pixels.
- STEP, 2: pixels moved per frame on each axis. Must satisfy STEP < V_ACT-BOX.
- BOX_COLOR, 8'hE0: square colour.

Ports:
- clk  in  1  pixel clock; everything runs in this domain.
- rst_n  in  1  reset, asynchronous, active-low.
- hs  in  1  horizontal sync from timing generator (active low).
- vs  in  1  vertical sync from timing generator (active low).
- line_cnt  in  WIDTH+2  horizontal scan counter.
- ver_cnt  in  WIDTH+2  vertical scan counter.
- en  in  1  1 = motion enabled; 0 = position frozen.
- bg_rgb  in  8  background colour inside the active area.
- hs_o  out  1  hs delayed 1 cycle.
- vs_o  out  1  vs delayed 1 cycle.
- rgb_o  out  8  composited pixel, aligned with hs_o/vs_o.
- frame_tick  out  1  one-cycle pulse on each vs falling edge.
- box_x  out  WIDTH  current square left edge, in active-area pixels.
- box_y  out  WIDTH  current square top edge, in active-area lines.

## Operation
- Frame detect:
  - vs_d register, reset 1.
  - frame_tick = registered (vs_d & ~vs), so it asserts the cycle after vs is first seen low.
- Position state: box_x, box_y, x_dir, y_dir (1 = increasing). Reset values: 0, 0, 1, 1.
- On frame_tick with en=1, each axis updates independently. X axis, with XMAX = H_ACT-BOX:
  - x_dir=1 and box_x+STEP >= XMAX: box_x <= XMAX, x_dir <= 0.
  - x_dir=0 and box_x <= STEP: box_x <= 0, x_dir <= 1.
  - Otherwise: box_x <= box_x ± STEP.
  - Y axis is identical, using YMAX = V_ACT-BOX and y_dir.
- Arithmetic: comparisons are done at WIDTH+1 bits so the sums cannot overflow. box_x never leaves [0, XMAX] and box_y never leaves [0, YMAX].
- en=0 during frame_tick: position and direction are unchanged. frame_tick still pulses.
- Position only changes during vertical sync, so it is constant across every active frame.
- Pixel path (combinational decode, one output register):
  - active = H_OFS <= line_cnt < H_OFS+H_ACT and V_OFS <= ver_cnt < V_OFS+V_ACT.
  - px = line_cnt-H_OFS, py = ver_cnt-V_OFS.
  - inside = box_x <= px < box_x+BOX and box_y <= py < box_y+BOX.
  - rgb_o <= active ? (inside ? BOX_COLOR : bg_rgb) : 8'h00.
- Reset values of outputs: rgb_o = 0, hs_o = 1, vs_o = 1, frame_tick = 0, box_x = 0, box_y = 0.
- Reset asserted mid-frame clears all state immediately. Motion restarts from (0,0) heading +x,+y.

## Timing
- rgb_o, hs_o and vs_o have 1 cycle of latency relative to their inputs. All three are mutually aligned.
- frame_tick goes high 1 cycle after vs goes low and lasts exactly 1 cycle per frame, whatever the length of the vs low pulse.
- box_x and box_y update on the clock edge that samples frame_tick=1, so the new values are visible 2 cycles after the vs falling edge.
- A square at box_x=0 starts exactly at line_cnt=H_OFS. A square at box_x=XMAX ends at the last active pixel; there is no partial clipping.
- No handshakes. The block never stalls and accepts input every cycle.

## Test plan
- Reset: hold rst_n=0 with random inputs → rgb_o=0, hs_o=1, vs_o=1, box_x=0, box_y=0, frame_tick=0. Release, then drive one vs pulse → exactly one frame_tick, followed by box_x=2, box_y=2.
- Right-wall bounce: advance frames until box_x=606 with x_dir=1 → next tick box_x=608; following tick box_x=606; no value above 608 ever appears.
- Left/top bounce: box_y=2 with y_dir=0 → next tick box_y=0, y_dir=1; the tick after that gives box_y=2.
- Pixel compose, with box at (0,0), bg_rgb=8'h1C:
  - line_cnt=144, ver_cnt=35 → rgb_o=8'hE0 one cycle later.
  - line_cnt=176, ver_cnt=35 → 8'h1C.
  - line_cnt=143 → 8'h00.
  - ver_cnt=515 → 8'h00.
- Freeze: en=0 over 5 frames → 5 frame_tick pulses, box_x and box_y unchanged. Set en=1 → motion resumes in the prior direction.
- Mid-frame reset: assert rst_n=0 asynchronously between clock edges during active video → outputs clear without waiting for a clock edge. After release, the first tick moves the square to (2,2).
